// File: rtl/encoder_pos_ctrl_if.sv
// Signal bundle between the encoder position controller and its decoder / UI environment.
// The master modport is the controller side; slave is the decoder and menu logic.
interface encoder_pos_ctrl_if #(
    parameter int unsigned W = 8
);
    logic [1:0]   opc;
    logic         err_in;
    logic         clr;
    logic         wrap_en;
    logic         enc_rst;
    logic         ready;
    logic [W-1:0] pos;
    logic         moved;
    logic         dir;
    logic         limit;
    logic         err;
    logic [7:0]   err_cnt;

    modport master (
        input  opc, err_in, clr, wrap_en,
        output enc_rst, ready, pos, moved, dir, limit, err, err_cnt
    );

    modport slave (
        output opc, err_in, clr, wrap_en,
        input  enc_rst, ready, pos, moved, dir, limit, err, err_cnt
    );
endinterface

// File: rtl/encoder_pos_ctrl.sv
// Sequences the quadrature decoder (reset, sync, fault recovery) and turns its step codes
// into a bounded detent position.
module encoder_pos_ctrl #(
    parameter int unsigned W         = 8,
    parameter int unsigned POS_MIN   = 0,
    parameter int unsigned POS_MAX   = 99,
    parameter int unsigned INIT_POS  = 0,
    parameter int unsigned DIV       = 4,
    parameter int unsigned RST_CYC   = 2,
    parameter int unsigned SYNC_TO   = 4,
    parameter int unsigned RETRY_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    encoder_pos_ctrl_if.master  bus
);
    typedef enum logic [1:0] {StInit, StSync, StRun, StFault} state_e;

    localparam logic [W-1:0]      PosMin  = W'(POS_MIN);
    localparam logic [W-1:0]      PosMax  = W'(POS_MAX);
    localparam logic [W-1:0]      PosInit = W'(INIT_POS);
    localparam logic signed [4:0] DivS    = 5'(DIV);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic signed [4:0]   sub_q, sub_d;
    logic [W-1:0]        pos_q, pos_d;
    logic                moved_q, moved_d;
    logic                dir_q, dir_d;
    logic                limit_q, limit_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                fault_entry;
    logic                step_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        unique case (state_q)
            StInit: begin
                if (cnt_q == 8'(RST_CYC - 1)) begin
                    state_d = StSync;
                    cnt_d   = '0;
                end
            end
            StSync: begin
                // A decoder error outranks a start code; a late start code outranks the timeout.
                if (bus.err_in) begin
                    state_d = StFault;
                    cnt_d   = '0;
                end else if (bus.opc == 2'b11) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == 8'(SYNC_TO - 1)) begin
                    state_d = StFault;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (bus.err_in || bus.opc == 2'b11) state_d = StFault;
            end
            StFault: begin
                if (cnt_q == 8'(RETRY_CYC - 1)) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    assign fault_entry = (state_d == StFault) && (state_q != StFault);
    assign step_ok     = (state_q == StRun) && !bus.err_in &&
                         (bus.opc == 2'b01 || bus.opc == 2'b10);

    always_comb begin
        pos_d     = pos_q;
        sub_d     = sub_q;
        moved_d   = 1'b0;
        limit_d   = 1'b0;
        dir_d     = dir_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (bus.clr) begin
            pos_d     = PosInit;
            sub_d     = '0;
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (step_ok) begin
            if (bus.opc == 2'b01) begin
                if (sub_q == DivS - 5'sd1) begin
                    sub_d = '0;
                    if (pos_q != PosMax) begin
                        pos_d   = pos_q + 1'b1;
                        moved_d = 1'b1;
                        dir_d   = 1'b1;
                    end else if (bus.wrap_en) begin
                        pos_d   = PosMin;
                        moved_d = 1'b1;
                        dir_d   = 1'b1;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    sub_d = sub_q + 5'sd1;
                end
            end else begin
                if (sub_q == 5'sd1 - DivS) begin
                    sub_d = '0;
                    if (pos_q != PosMin) begin
                        pos_d   = pos_q - 1'b1;
                        moved_d = 1'b1;
                        dir_d   = 1'b0;
                    end else if (bus.wrap_en) begin
                        pos_d   = PosMax;
                        moved_d = 1'b1;
                        dir_d   = 1'b0;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    sub_d = sub_q - 5'sd1;
                end
            end
        end
        // Fault entry applies on top of a simultaneous clear.
        if (fault_entry) begin
            err_d = 1'b1;
            if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            sub_q     <= '0;
            pos_q     <= PosInit;
            moved_q   <= 1'b0;
            dir_q     <= 1'b0;
            limit_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            pos_q     <= pos_d;
            moved_q   <= moved_d;
            dir_q     <= dir_d;
            limit_q   <= limit_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.enc_rst = (state_q == StInit) || (state_q == StFault);
    assign bus.ready   = (state_q == StRun);
    assign bus.pos     = pos_q;
    assign bus.moved   = moved_q;
    assign bus.dir     = dir_q;
    assign bus.limit   = limit_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule
